// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RISC-V core.
// ALU results pass straight through. Loads and stores run as little-endian
// byte-serial transfers on the 8-bit memory-controller port, and the
// pipeline is stalled until each access completes.
// Optional build macro: MEM_ALIGN_CHECK_EN adds mem_misalign and turns
// misaligned half/word accesses into no-ops.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_vd,
  input  logic              ex_w_enable,
  input  logic [3:0]        ex_mem_op,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        mem_rd,
  output logic [DATA_W-1:0] mem_vd,
  output logic              mem_w_enable,
  output logic              stall_req_mem,
  output logic              mc_valid,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [7:0]        mc_wdata,
  input  logic              mc_ready,
  input  logic [7:0]        mc_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              mem_misalign
`endif
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] sd_q;
  logic [4:0]        rd_q;
  logic              we_q;
  logic [1:0]        cnt;
  logic [3:0][7:0]   rbuf;

  logic op_valid, fault, start, is_store;
  logic [1:0] last_idx;
  logic [DATA_W-1:0] ld_val;

  // Last byte index of the access: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] len_m1(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: len_m1 = 2'd1;
      OP_LW, OP_SW:         len_m1 = 2'd3;
      default:              len_m1 = 2'd0;
    endcase
  endfunction

  assign op_valid = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
  assign fault = op_valid &&
                 ((((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH)) && ex_vd[0]) ||
                  (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW)) && (ex_vd[1:0] != 2'b00)));
`else
  assign fault = 1'b0;
`endif
  assign start    = op_valid && !fault;
  assign is_store = (op_q >= OP_SB);
  assign last_idx = len_m1(op_q);

  // Sign/zero extension of the assembled load bytes.
  always_comb begin
    ld_val = DATA_W'(rbuf);
    case (op_q)
      OP_LB:   ld_val = {{(DATA_W-8){rbuf[0][7]}}, rbuf[0]};
      OP_LH:   ld_val = {{(DATA_W-16){rbuf[1][7]}}, rbuf[1], rbuf[0]};
      OP_LBU:  ld_val = DATA_W'(rbuf[0]);
      OP_LHU:  ld_val = DATA_W'({rbuf[1], rbuf[0]});
      default: ld_val = DATA_W'(rbuf);
    endcase
  end

  // Next-state logic: a byte completes only when the request is live (BUSY).
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (mc_ready && (cnt == last_idx)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; rdy low freezes the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_d;
  end

  // Access context latch, byte counter and load assembly buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0; base_q <= '0; sd_q <= '0; rd_q <= '0; we_q <= 1'b0;
      cnt  <= '0; rbuf <= '0;
    end else if (rdy) begin
      if (state == IDLE && start) begin
        op_q   <= ex_mem_op;
        base_q <= ex_vd[ADDR_W-1:0];
        sd_q   <= ex_store_data;
        rd_q   <= ex_rd;
        we_q   <= ex_w_enable;
        cnt    <= '0;
        rbuf   <= '0;
      end else if (state == BUSY && mc_ready) begin
        if (!is_store) rbuf[cnt] <= mc_rdata;
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    mem_rd        = '0;
    mem_vd        = '0;
    mem_w_enable  = 1'b0;
    stall_req_mem = 1'b0;
    mc_valid      = 1'b0;
    mc_wr         = 1'b0;
    mc_addr       = '0;
    mc_wdata      = '0;
`ifdef MEM_ALIGN_CHECK_EN
    mem_misalign  = 1'b0;
`endif
    if (rst) begin
      case (state)
        IDLE: begin
          if (start) begin
            stall_req_mem = 1'b1;
          end else if (fault) begin
`ifdef MEM_ALIGN_CHECK_EN
            mem_misalign = 1'b1;
`endif
          end else begin
            mem_rd       = ex_rd;
            mem_vd       = ex_vd;
            mem_w_enable = ex_w_enable;
          end
        end
        BUSY: begin
          stall_req_mem = 1'b1;
          mc_valid      = 1'b1;
          mc_wr         = is_store;
          mc_addr       = base_q + ADDR_W'(cnt);
          mc_wdata      = sd_q[{cnt, 3'b000} +: 8];
        end
        DONE: begin
          if (!is_store) begin
            mem_rd       = rd_q;
            mem_vd       = ld_val;
            mem_w_enable = we_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: an instruction-level model (byte memory
// image plus expected bus sequence per access) drives expectations that a
// single negedge compare process checks every cycle.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  ex_rd;
  logic [31:0] ex_vd, ex_store_data;
  logic        ex_w_enable;
  logic [3:0]  ex_mem_op;
  logic [4:0]  mem_rd;
  logic [31:0] mem_vd;
  logic        mem_w_enable, stall_req_mem, mc_valid, mc_wr;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic        mc_ready;
  logic [7:0]  mc_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_misalign;
`endif

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_rd(ex_rd), .ex_vd(ex_vd), .ex_w_enable(ex_w_enable),
    .ex_mem_op(ex_mem_op), .ex_store_data(ex_store_data),
    .mem_rd(mem_rd), .mem_vd(mem_vd), .mem_w_enable(mem_w_enable),
    .stall_req_mem(stall_req_mem), .mc_valid(mc_valid), .mc_wr(mc_wr),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
    .mc_rdata(mc_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  always #5 clk = ~clk;

  localparam int PH_NONE = 0, PH_PASS = 1, PH_IOP = 2, PH_BUSY = 3,
                 PH_DONE = 4, PH_RST = 5, PH_MIS = 6;

  int          n_tests = 0, n_fail = 0;
  int          phase = PH_NONE;
  logic [4:0]  exp_rd;
  logic [31:0] exp_vd, exp_base, exp_sd;
  logic        exp_we, exp_st;
  int          exp_k;
  int          stall_cnt;
  logic [31:0] done_vd;
  logic [7:0]  bus_mem [256];   // what the memory controller actually holds
  logic [7:0]  ref_mem [256];   // model image updated at instruction level

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model's expectation for the current phase.
  always @(negedge clk) begin
    case (phase)
      PH_PASS: begin
        chk("pass_rd", mem_rd, exp_rd);
        chk("pass_vd", mem_vd, exp_vd);
        chk("pass_we", mem_w_enable, exp_we);
        chk("pass_stall", stall_req_mem, 0);
        chk("pass_mcv", mc_valid, 0);
      end
      PH_IOP: begin
        stall_cnt = stall_req_mem ? 1 : 0;
        chk("iop_stall", stall_req_mem, 1);
        chk("iop_we", mem_w_enable, 0);
        chk("iop_mcv", mc_valid, 0);
      end
      PH_BUSY: begin
        if (stall_req_mem) stall_cnt++;
        chk("busy_mcv", mc_valid, 1);
        chk("busy_wr", mc_wr, exp_st);
        chk("busy_addr", mc_addr, exp_base + 32'(exp_k));
        if (exp_st) chk("busy_wdata", mc_wdata, 32'(exp_sd[8*exp_k +: 8]));
        chk("busy_stall", stall_req_mem, 1);
        chk("busy_we", mem_w_enable, 0);
      end
      PH_DONE: begin
        if (stall_req_mem) stall_cnt++;
        done_vd = mem_vd;
        chk("done_stall", stall_req_mem, 0);
        chk("done_mcv", mc_valid, 0);
        chk("done_rd", mem_rd, exp_rd);
        chk("done_vd", mem_vd, exp_vd);
        chk("done_we", mem_w_enable, exp_we);
      end
      PH_RST: begin
        chk("rst_outs", {mem_rd, mem_vd, mem_w_enable, stall_req_mem, mc_valid, mc_wr}, 0);
        chk("rst_bus", {mc_addr, mc_wdata}, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_mis", mem_misalign, 0);
`endif
      end
      PH_MIS: begin
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_flag", mem_misalign, 1);
`endif
        chk("mis_mcv", mc_valid, 0);
        chk("mis_stall", stall_req_mem, 0);
        chk("mis_outs", {mem_rd, mem_vd, mem_w_enable}, 0);
      end
      default: ;
    endcase
  end

  task automatic pass_op(input logic [3:0] o, input logic [4:0] r, input logic [31:0] v, input logic we);
    ex_mem_op = o; ex_rd = r; ex_vd = v; ex_w_enable = we; ex_store_data = $urandom;
    mc_ready = 1'($urandom % 2); rdy = 1'b1;
    exp_rd = r; exp_vd = v; exp_we = we; phase = PH_PASS;
    @(posedge clk); #1; phase = PH_NONE;
  endtask

  // One memory instruction: model computes bus sequence and result from the
  // byte image; rnd selects random rdy/mc_ready, else wait0 stalls on byte 0.
  task automatic do_op(input logic [3:0] o, input logic [4:0] r, input logic [31:0] a,
                       input logic we, input logic [31:0] sd, input bit rnd, input int wait0);
    int len, k, cyc;
    bit st, hk;
    logic [31:0] v;
    len = (o == 1 || o == 4 || o == 6) ? 1 : (o == 2 || o == 5 || o == 7) ? 2 : 4;
    st  = (o >= 6);
    ex_mem_op = o; ex_rd = r; ex_vd = a; ex_w_enable = we; ex_store_data = sd;
    mc_ready = 1'($urandom % 2); rdy = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
    if ((len == 2 && a[0]) || (len == 4 && a[1:0] != 0)) begin
      phase = PH_MIS;
      @(posedge clk); #1; phase = PH_NONE;
      return;
    end
`endif
    v = 0;
    for (int i = 0; i < len; i++) v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
    if (o == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (o == 2 && v[15]) v = v | 32'hFFFF_0000;
    if (st) for (int i = 0; i < len; i++) ref_mem[8'(a + 32'(i))] = sd[8*i +: 8];
    exp_st = st; exp_base = a; exp_sd = sd;
    exp_rd = st ? 5'd0 : r; exp_we = st ? 1'b0 : we; exp_vd = st ? 32'd0 : v;
    phase = PH_IOP;
    @(posedge clk); #1;
    k = 0; cyc = 0;
    while (k < len && cyc < 64) begin
      if (rnd) begin
        rdy = ($urandom % 6) != 0;
        mc_ready = ($urandom % 3) != 0;
      end else begin
        rdy = 1'b1;
        mc_ready = !(k == 0 && cyc < wait0);
      end
      mc_rdata = bus_mem[mc_addr[7:0]];
      exp_k = k; phase = PH_BUSY;
      hk = rdy && mc_ready;
      if (hk && mc_valid && mc_wr) bus_mem[mc_addr[7:0]] = mc_wdata;
      @(posedge clk); #1;
      if (hk) k++;
      cyc++;
    end
    if (k < len) chk("busy_timeout", k, len);
    rdy = 1'b1; mc_ready = 1'($urandom % 2); phase = PH_DONE;
    @(posedge clk); #1; phase = PH_NONE;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom); ref_mem[i] = bus_mem[i];
    end
    rst = 1'b0; rdy = 1'b1; mc_ready = 1'b1; mc_rdata = 8'h5A;
    ex_mem_op = 4'd3; ex_rd = 5'd9; ex_vd = 32'hDEAD_BEEF; ex_w_enable = 1'b1; ex_store_data = '1;
    phase = PH_RST;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; phase = PH_NONE;

    // ALU passthrough, including codes treated as none
    pass_op(4'd0, 5'd5, 32'h1234, 1'b1);
    pass_op(4'd9, 5'd17, 32'hCAFE_0001, 1'b0);
    pass_op(4'd15, 5'd31, 32'h8000_0000, 1'b1);

    // LW with ready every cycle
    bus_mem[8'h00] = 8'h78; bus_mem[8'h01] = 8'h56; bus_mem[8'h02] = 8'h34; bus_mem[8'h03] = 8'h12;
    for (int i = 0; i < 4; i++) ref_mem[i] = bus_mem[i];
    do_op(4'd3, 5'd7, 32'h100, 1'b1, 32'h0, 1'b0, 0);
    chk("lw_vd_lit", done_vd, 32'h1234_5678);
    chk("lw_stall_lit", stall_cnt, 5);

    // LB / LBU / LH sign handling
    bus_mem[8'h80] = 8'h80; ref_mem[8'h80] = 8'h80;
    bus_mem[8'h90] = 8'h00; ref_mem[8'h90] = 8'h00;
    bus_mem[8'h91] = 8'h80; ref_mem[8'h91] = 8'h80;
    do_op(4'd1, 5'd1, 32'h80, 1'b1, 32'h0, 1'b0, 0);
    chk("lb_lit", done_vd, 32'hFFFF_FF80);
    do_op(4'd4, 5'd2, 32'h80, 1'b1, 32'h0, 1'b0, 0);
    chk("lbu_lit", done_vd, 32'h0000_0080);
    do_op(4'd2, 5'd3, 32'h90, 1'b1, 32'h0, 1'b0, 0);
    chk("lh_lit", done_vd, 32'hFFFF_8000);

    // SH misaligned with two wait cycles on byte 0
    do_op(4'd7, 5'd4, 32'h201, 1'b1, 32'h0000_ABCD, 1'b0, 2);
`ifndef MEM_ALIGN_CHECK_EN
    chk("sh_b0_lit", bus_mem[8'h01], 8'hCD);
    chk("sh_b1_lit", bus_mem[8'h02], 8'hAB);
    chk("sh_stall_lit", stall_cnt, 5);
    // word crossing the top of the address space
    do_op(4'd3, 5'd6, 32'hFFFF_FFFE, 1'b1, 32'h0, 1'b1, 0);
`endif

    // reset in the middle of an LW
    ex_mem_op = 4'd3; ex_rd = 5'd8; ex_vd = 32'h140; ex_w_enable = 1'b1; rdy = 1'b1;
    exp_st = 1'b0; exp_base = 32'h140; exp_sd = 0; exp_k = 0;
    phase = PH_IOP; @(posedge clk); #1;
    mc_ready = 1'b1; mc_rdata = bus_mem[mc_addr[7:0]]; phase = PH_BUSY;
    @(posedge clk); #1;
    phase = PH_NONE; rst = 1'b0; #1;
    chk("rst_async_mcv", mc_valid, 0);
    chk("rst_async_stall", stall_req_mem, 0);
    phase = PH_RST; @(posedge clk); #1;
    rst = 1'b1; phase = PH_NONE;
    pass_op(4'd0, 5'd11, 32'h55AA_55AA, 1'b1);
    do_op(4'd3, 5'd12, 32'h140, 1'b1, 32'h0, 1'b0, 0);

`ifdef MEM_ALIGN_CHECK_EN
    do_op(4'd3, 5'd13, 32'h102, 1'b1, 32'h0, 1'b0, 0);
`endif

    // randomized mix of ALU and memory ops
    for (int n = 0; n < 200; n++) begin
      logic [3:0] o;
      logic [31:0] a;
      o = 4'($urandom_range(0, 15));
      a = ($urandom % 8 == 0) ? 32'hFFFF_FFFC + 32'($urandom % 4) : 32'h100 + 32'($urandom % 256);
      if (o == 0 || o > 8) pass_op(o, 5'($urandom), $urandom, 1'($urandom));
      else do_op(o, 5'($urandom), a, 1'($urandom), $urandom, 1'b1, 0);
    end

    // stored bytes must have reached the controller's memory
    for (int i = 0; i < 256; i += 17) chk("mem_img", bus_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It passes ALU results straight through. It executes loads and stores as little-endian byte-serial transfers on the 8-bit memory-controller port, and holds the pipeline through a stall request until each access completes. Its mem_rd/mem_vd/mem_w_enable outputs feed MEM/WB and the ID-stage forwarding path.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, register/data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; when low, all state holds
- ex_rd  in  5  destination register
- ex_vd  in  32  ALU result; this is the effective address for memory ops
- ex_w_enable  in  1  register write enable
- ex_mem_op  in  4  memory operation: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9–15 are treated as none
- ex_store_data  in  32  store data (rs2)
- mem_rd  out  5  to MEM/WB
- mem_vd  out  32  to MEM/WB
- mem_w_enable  out  1  to MEM/WB
- stall_req_mem  out  1  stall request to the stall controller
- mc_valid  out  1  byte request valid
- mc_wr  out  1  1 = write byte, 0 = read byte
- mc_addr  out  32  byte address
- mc_wdata  out  8  write byte
- mc_ready  in  1  current byte transfer completes this cycle
- mc_rdata  in  8  read byte; valid when mc_ready=1 and mc_wr=0
- mem_misalign  out  1  only present with MEM_ALIGN_CHECK_EN

## Operation
FSM states: IDLE, BUSY, DONE.

- **IDLE, op none:** outputs pass through combinationally: mem_rd=ex_rd, mem_vd=ex_vd, mem_w_enable=ex_w_enable. stall_req_mem=0. mc_valid=0.
- **IDLE, op valid:**
  - Latch op, base address (ex_vd), store data, ex_rd and ex_w_enable.
  - Clear the byte counter cnt and the assembly buffer.
  - Go to BUSY.
  - stall_req_mem=1 combinationally in this cycle.
  - mem_w_enable=0.
- **BUSY:**
  - Drive mc_valid=1, mc_wr=store, mc_addr=base+cnt (modulo 2^32), mc_wdata=store_data[8*cnt+7:8*cnt].
  - Keep mc_valid, mc_wr, mc_addr and mc_wdata stable until mc_ready.
  - On mc_ready for a load, write mc_rdata into buffer byte cnt.
  - On mc_ready, cnt increments. When cnt = len−1, go to DONE.
  - len is 1 for B/BU, 2 for H/HU, 4 for W.
  - stall_req_mem=1; mem_w_enable=0.
- **DONE:** lasts exactly one cycle, then IDLE.
  - stall_req_mem=0; mc_valid=0.
  - Load: mem_rd=latched rd; mem_w_enable=latched w_enable; mem_vd=buffer, extended.
    - LB sign-extends bit 7; LH sign-extends bit 15.
    - LBU and LHU zero-extend.
  - Store: mem_rd=0, mem_vd=0, mem_w_enable=0.

Rules:
- Misaligned half/word accesses proceed byte-serially unless MEM_ALIGN_CHECK_EN is defined.
- mc_ready while mc_valid=0 is ignored.
- rdy=0 freezes state, cnt and buffer. Outputs still reflect the frozen state, and mc_valid stays asserted in BUSY.
- While rst is low:
  - State returns to IDLE immediately, and cnt and buffer are cleared.
  - All outputs are 0: mem_rd, mem_vd, mem_w_enable, stall_req_mem, mc_valid, mc_wr, mc_addr, mc_wdata, and mem_misalign.
  - A transfer in flight is abandoned without completion.

## Timing
- A non-memory instruction has zero latency and no stall.
- Memory op first seen in IDLE at cycle T:
  - With mc_ready every cycle, bytes complete at T+1 … T+len.
  - DONE occurs at T+len+1.
  - stall_req_mem is high for cycles T … T+len, i.e. len+1 cycles.
- Each wait cycle with mc_ready=0 extends BUSY, and the stall, by one cycle.
- The EX/MEM register advances on the edge ending DONE. The next instruction is therefore seen in IDLE at T+len+2.
- Back-to-back memory ops get no bubble beyond this.

## Configuration
MEM_ALIGN_CHECK_EN:
- **Defined:**
  - An alignment fault is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - On a fault, mem_misalign=1 for one cycle in IDLE.
  - The op becomes a no-op: no bus traffic, no stall, mem_w_enable=0, mem_rd=0, mem_vd=0.
- **Undefined:**
  - The mem_misalign port is absent.
  - Misaligned accesses execute as normal byte-serial transfers.

## Test plan
- ALU passthrough: mem_op=0, ex_rd=5, ex_vd=0x1234, ex_w_enable=1 -> same-cycle mem_rd=5, mem_vd=0x1234, mem_w_enable=1, stall_req_mem=0.
- LW: addr 0x100, mc_rdata 0x78,0x56,0x34,0x12, mc_ready every cycle:
  - mc_addr sequence is 0x100–0x103.
  - stall_req_mem is high for 5 cycles.
  - DONE gives mem_vd=0x12345678 with mem_w_enable=1.
- LB vs LBU: byte 0x80 at 0x80 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH of bytes 0x00,0x80 gives 0xFFFF8000.
- SH: addr 0x201, data 0xABCD, mc_ready held low for 2 cycles on byte 0:
  - Writes 0xCD@0x201, then 0xAB@0x202.
  - mc_addr and mc_wdata stay stable during the wait.
  - Stall lasts 5 cycles; DONE has mem_w_enable=0.
- rdy/reset: rdy=0 for 3 cycles mid-LW -> no progress and mc_valid stays held. rst low mid-LW -> all outputs 0 immediately. After rst goes high, the next op is handled from IDLE.
- MEM_ALIGN_CHECK_EN defined, LW at 0x102 -> mem_misalign=1, no mc_valid, no stall, mem_w_enable=0.
